// File: rtl/msgpass_waddr_gen_pkg.sv
// msgpass_waddr_gen_pkg: sizing constants and FSM state type for the message-pass write path
package msgpass_waddr_gen_pkg;
  localparam int MSGPASS_LAYER_NUM = 4;
  localparam int MSGPASS_ROW_NUM = 8;
  localparam int MEMSHARE_DRC_NUM = 4;
  localparam int MSGPASS_BUFF_ADDR_WIDTH = 6;
  localparam int MSGPASS_SHARE_BASE = MSGPASS_LAYER_NUM * MSGPASS_ROW_NUM;
  typedef enum logic [1:0] {IDLE, RUN, DONE} waddr_state_t;
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/msgpass_waddr_gen_drc_enc.sv
// msgpass_waddr_gen_drc_enc: one-hot to binary DRC slot encoder, lowest set bit wins
module msgpass_waddr_gen_drc_enc
  import msgpass_waddr_gen_pkg::*;
#(
  parameter int N = MEMSHARE_DRC_NUM,
  parameter int SW = clog2_min1(N)
) (
  input  logic [N-1:0]  i_onehot,
  output logic [SW-1:0] o_slot,
  output logic          o_multi_hot
);
  always_comb begin
    o_slot = '0;
    for (int i = N - 1; i >= 0; i--) o_slot = i_onehot[i] ? SW'(i) : o_slot;
  end
  assign o_multi_hot = |(i_onehot & (i_onehot - 1'b1));
endmodule

// File: rtl/msgpass_waddr_gen.sv
// msgpass_waddr_gen: turns the SCU message stream into registered message-pass buffer writes,
// redirecting DRC-flagged words to the shared region
module msgpass_waddr_gen
  import msgpass_waddr_gen_pkg::*;
#(
  parameter int LAYER_NUM = MSGPASS_LAYER_NUM,
  parameter int ROW_NUM = MSGPASS_ROW_NUM,
  parameter int DRC_NUM = MEMSHARE_DRC_NUM,
  parameter int ADDR_WIDTH = MSGPASS_BUFF_ADDR_WIDTH,
  parameter int SHARE_BASE = LAYER_NUM * ROW_NUM,
  parameter int LID_W = clog2_min1(LAYER_NUM)
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  wr_start_i,
  input  logic [LID_W-1:0]      layer_id_i,
  input  logic                  msg_valid_i,
  output logic                  msg_ready_o,
  input  logic [DRC_NUM-1:0]    is_drc_i,
  input  logic                  wr_stall_i,
  output logic [ADDR_WIDTH-1:0] waddr_o,
  output logic                  wen_o,
  output logic                  wdrc_o,
  output logic                  layer_done_o,
  output logic                  busy_o,
  output logic                  err_o
);
  localparam int RW = clog2_min1(ROW_NUM);
  localparam int SW = clog2_min1(DRC_NUM);
  waddr_state_t r_state;
  logic [LID_W-1:0] r_layer;
  logic [RW-1:0] r_row_cnt;
  logic [SW-1:0] w_slot;
  logic w_multi, w_drc, w_acc, w_last, w_load, w_bad_lid;
  logic [ADDR_WIDTH-1:0] w_norm, w_share;

  msgpass_waddr_gen_drc_enc #(.N(DRC_NUM), .SW(SW)) u_enc (
    .i_onehot(is_drc_i),
    .o_slot(w_slot),
    .o_multi_hot(w_multi)
  );

  assign msg_ready_o = (r_state == RUN) && !wr_stall_i;
  assign busy_o = r_state != IDLE;
  assign w_acc = msg_valid_i && msg_ready_o;
  assign w_last = 32'(r_row_cnt) == ROW_NUM - 1;
  // a start in DONE chains straight into the next layer without an IDLE bubble
  assign w_load = wr_start_i && (r_state != RUN);
  assign w_bad_lid = 32'(layer_id_i) >= LAYER_NUM;
  assign w_drc = |is_drc_i;
  assign w_norm = ADDR_WIDTH'(r_layer) * ADDR_WIDTH'(ROW_NUM) + ADDR_WIDTH'(r_row_cnt);
  assign w_share = ADDR_WIDTH'(SHARE_BASE) + ADDR_WIDTH'(w_slot);

  always_ff @(posedge sys_clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_layer <= '0;
      r_row_cnt <= '0;
      waddr_o <= '0;
      wen_o <= 1'b0;
      wdrc_o <= 1'b0;
      layer_done_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      wen_o <= w_acc;
      wdrc_o <= w_acc && w_drc;
      layer_done_o <= w_acc && w_last;
      err_o <= err_o || (w_acc && w_multi) || (w_load && w_bad_lid);
      if (w_acc) waddr_o <= w_drc ? w_share : w_norm;
      if (w_load) begin
        r_state <= RUN;
        r_layer <= layer_id_i;
        r_row_cnt <= '0;
      end else if (r_state == DONE) r_state <= IDLE;
      else if (w_acc) begin
        r_row_cnt <= w_last ? '0 : r_row_cnt + 1'b1;
        r_state <= w_last ? DONE : RUN;
      end
    end
endmodule

// File: tb/tb_msgpass_waddr_gen.sv
// tb_msgpass_waddr_gen: directed plus random stimulus against a per-cycle behavioural model
module tb_msgpass_waddr_gen;
  logic sys_clk = 1'b0, rst = 1'b1, wr_start_i = 1'b0, msg_valid_i = 1'b0, wr_stall_i = 1'b0;
  logic [2:0] layer_id_i = '0;
  logic [3:0] is_drc_i = '0;
  logic msg_ready_o, wen_o, wdrc_o, layer_done_o, busy_o, err_o;
  logic [5:0] waddr_o;
  int checks = 0, errors = 0;
  bit m_run, m_fin, m_wen, m_pulse, m_drc, m_err;
  int m_layer, m_cnt, m_addr;

  msgpass_waddr_gen #(.LID_W(3)) dut (
    .sys_clk(sys_clk), .rst(rst), .wr_start_i(wr_start_i), .layer_id_i(layer_id_i),
    .msg_valid_i(msg_valid_i), .msg_ready_o(msg_ready_o), .is_drc_i(is_drc_i),
    .wr_stall_i(wr_stall_i), .waddr_o(waddr_o), .wen_o(wen_o), .wdrc_o(wdrc_o),
    .layer_done_o(layer_done_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_addr(input int l, input int c, input logic [3:0] d);
    for (int i = 0; i < 4; i++) if (d[i]) return 32 + i;
    return (l * 8 + c) % 64;
  endfunction

  task automatic model_clear();
    m_run = 0; m_fin = 0; m_wen = 0; m_pulse = 0; m_drc = 0; m_err = 0;
    m_layer = 0; m_cnt = 0; m_addr = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_waddr"}, 32'(waddr_o), 32'd0);
    chk({tag, "_wen"}, 32'(wen_o), 32'd0);
    chk({tag, "_wdrc"}, 32'(wdrc_o), 32'd0);
    chk({tag, "_done"}, 32'(layer_done_o), 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_err"}, 32'(err_o), 32'd0);
    chk({tag, "_ready"}, 32'(msg_ready_o), 32'd0);
  endtask

  task automatic cyc(input bit st, input int lid, input bit v, input logic [3:0] d, input bit s);
    bit acc, nfin;
    wr_start_i = st; layer_id_i = 3'(lid); msg_valid_i = v; is_drc_i = d; wr_stall_i = s;
    @(negedge sys_clk);
    chk("ready", 32'(msg_ready_o), 32'(m_run && !s));
    chk("busy", 32'(busy_o), 32'(m_run || m_fin));
    chk("wen", 32'(wen_o), 32'(m_wen));
    chk("wdrc", 32'(wdrc_o), 32'(m_drc));
    chk("layer_done", 32'(layer_done_o), 32'(m_pulse));
    chk("err", 32'(err_o), 32'(m_err));
    if (m_wen) chk("waddr", 32'(waddr_o), 32'(m_addr));
    acc = v && m_run && !s;
    nfin = 0; m_wen = acc; m_pulse = 0; m_drc = acc && (d != 0);
    if (acc) begin
      m_addr = exp_addr(m_layer, m_cnt, d);
      if ($countones(d) > 1) m_err = 1;
      m_cnt++;
      if (m_cnt == 8) begin m_run = 0; nfin = 1; m_pulse = 1; m_cnt = 0; end
    end else if (st && !m_run) begin
      m_run = 1; m_layer = lid; m_cnt = 0;
      if (lid >= 4) m_err = 1;
    end
    m_fin = nfin;
    @(posedge sys_clk); #1;
  endtask

  task automatic pass(input int lid, input int k, input logic [3:0] d);
    cyc(1, lid, 0, 4'b0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, (i == k) ? d : 4'b0, 0);
  endtask

  task automatic mid_reset();
    wr_start_i = 0; msg_valid_i = 0; is_drc_i = '0; wr_stall_i = 0;
    #2 rst = 1'b1;
    #1 chk_zero("async_rst");
    model_clear();
    @(posedge sys_clk);
    @(negedge sys_clk) rst = 1'b0;
    @(posedge sys_clk); #1;
  endtask

  initial begin
    logic [3:0] d;
    int r;
    model_clear();
    #3 chk_zero("reset");
    @(negedge sys_clk) rst = 1'b0;
    @(posedge sys_clk); #1;
    pass(2, -1, 4'b0);
    cyc(0, 0, 0, 4'b0, 0);
    pass(1, 3, 4'b0100);
    cyc(0, 0, 0, 4'b0, 0);
    cyc(1, 2, 0, 4'b0, 0);
    for (int i = 0; i < 11; i++) cyc(0, 0, 1, 4'b0, (i >= 4 && i < 7));
    cyc(0, 0, 0, 4'b0, 0);
    pass(0, -1, 4'b0);
    cyc(1, 3, 0, 4'b0, 0);
    for (int i = 0; i < 8; i++) cyc(i == 2, 1, 1, 4'b0, 0);
    cyc(0, 0, 0, 4'b0, 0);
    cyc(0, 0, 0, 4'b0, 0);
    cyc(1, 2, 0, 4'b0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 4'b0, 0);
    mid_reset();
    cyc(0, 0, 0, 4'b0, 0);
    pass(0, -1, 4'b0);
    cyc(0, 0, 0, 4'b0, 0);
    pass(3, 5, 4'b0110);
    cyc(0, 0, 0, 4'b0, 0);
    mid_reset();
    pass(5, -1, 4'b0);
    cyc(0, 0, 0, 4'b0, 0);
    mid_reset();
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 7));
      d = (r == 0) ? 4'(1 << $urandom_range(0, 3)) : (r == 1) ? 4'($urandom_range(0, 15)) : 4'b0;
      cyc($urandom_range(0, 5) == 0, int'($urandom_range(0, 4)), $urandom_range(0, 3) != 0, d,
          $urandom_range(0, 3) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
